divider_32_seq: RTL and testbench
=================================

// Module: divider_32_seq
// PURPOSE
//  Issue-side sequencer that sits directly upstream of divider_32 and drives it.
//  Accepts signed or unsigned divide requests over a valid/ready handshake and converts
//  operands to magnitudes. Starts divider_32, waits for dne, restores signs, and returns
//  the result over a valid/ready handshake. Resolves divide-by-zero and signed overflow
//  itself, without starting the divider.
// PARAMETERS
//  WIDTH    32  operand/result width; must match divider_32
//  TIMEOUT  64  max cycles spent in WAIT before aborting with out_err
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous, active-low reset (sampled on clk rising edge)
//  in_valid   in   1      request valid
//  in_ready   out  1      sequencer can accept request (high only in IDLE)
//  in_a       in   WIDTH  dividend
//  in_b       in   WIDTH  divisor
//  in_signed  in   1      1 = two's-complement operation, 0 = unsigned
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_q      out  WIDTH  quotient
//  out_r      out  WIDTH  remainder
//  out_dz     out  1      divide-by-zero flag for this result
//  out_err    out  1      divider timeout flag for this result
//  div_a      out  WIDTH  to divider_32 a (magnitude of dividend)
//  div_b      out  WIDTH  to divider_32 b (magnitude of divisor)
//  div_ena    out  1      to divider_32 ena
//  div_rst    out  1      to divider_32 rst (active-high computation restart)
//  div_q      in   WIDTH  from divider_32 q
//  div_r      in   WIDTH  from divider_32 r
//  div_dne    in   1      from divider_32 dne
// BEHAVIOUR
//  Reset (rst==0 at edge)
//   - state=IDLE
//   - in_ready=1
//   - out_valid, out_dz, out_err, div_rst, div_ena = 0
//   - out_q, out_r, div_a, div_b = 0
//   - Reset wins over every other event, including mid-WAIT: any in-flight op is dropped
//     with no output.
//  FSM states: IDLE, START, WAIT, FIX, DONE
//   IDLE:  in_ready=1. On in_valid, register operands, neg_q, neg_r, and flags.
//          - b==0: load q=all-ones, r=in_a, dz=1, then go to DONE.
//          - signed, a==MIN and b==-1: load q=MIN, r=0, then go to DONE.
//          - otherwise: div_a=|a|, div_b=|b| (|x| only if signed and x<0), then go to START.
//   START: div_rst=1, div_ena=1 for exactly one cycle, then go to WAIT.
//   WAIT:  div_ena=1, div_rst=0.
//          - div_dne is ignored in the first WAIT cycle (stale dne from the previous op).
//          - On div_dne, go to FIX.
//          - After TIMEOUT cycles in WAIT with no dne: q=0, r=0, err=1, then go to DONE.
//   FIX:   q = neg_q ? -div_q : div_q; r = neg_r ? -div_r : div_r; then go to DONE.
//          - neg_q = signed & (a[MSB]^b[MSB]); neg_r = signed & a[MSB]
//            (remainder takes the dividend's sign; truncating division).
//   DONE:  out_valid=1, outputs stable. On out_ready, go to IDLE; out_valid drops next cycle.
//  Outputs
//   - out_q, out_r, out_dz, and out_err are registered.
//   - They hold their value until the next result loads.
//   - out_dz and out_err are cleared when a normal result loads.
//  Timing and limits
//   - One op in flight. in_ready=0 in all states except IDLE; no request is accepted while
//     out_valid is high.
//   - Latency, accept edge to out_valid: 1 cycle for special cases; 3 + N cycles on the
//     divider path, where N = WAIT cycles.
//   - div_ena is low in IDLE and DONE so the divider is frozen.
//   - Negation is modulo 2^WIDTH; no other overflow is possible once MIN/-1 is trapped.
// TESTING
//  1. Unsigned 155/25 -> out_q=6, out_r=5, dz=0, err=0; div_rst high exactly 1 cycle.
//  2. Signed -155/25 (a=0xFFFFFF65) -> div_a=155, div_b=25; out_q=0xFFFFFFFA (-6),
//     out_r=0xFFFFFFFB (-5).
//  3. Unsigned 7/0 -> out_q=0xFFFFFFFF, out_r=7, dz=1; out_valid 1 cycle after accept;
//     div_rst never asserted.
//  4. Signed 0x80000000/0xFFFFFFFF -> out_q=0x80000000, out_r=0, dz=0; divider not started.
//  5. Hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0;
//     next request accepted only after release.
//  6. rst=0 mid-WAIT -> next cycle IDLE, in_ready=1, out_valid=0.
//     Stub divider that never asserts dne -> out_err=1, q=0, r=0 after TIMEOUT WAIT cycles.

Source files
------------

// File: rtl/divider_32_seq.sv
// Issue-side sequencer for divider_32: takes signed/unsigned requests, runs the divider on magnitudes, restores signs.
// Latency 1 cycle for divide-by-zero and MIN/-1, otherwise START + WAIT + FIX; holds the result in DONE until out_ready.
module divider_32_seq #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dz,
    output logic             out_err,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_ena,
    output logic             div_rst,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_dne
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FIX, S_DONE} state_t;

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            neg_q;
    logic            neg_r;
    logic            neg_a;
    logic            neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign neg_a = in_signed & in_a[WIDTH-1];
    assign neg_b = in_signed & in_b[WIDTH-1];
    assign mag_a = neg_a ? -in_a : in_a;
    assign mag_b = neg_b ? -in_b : in_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dz    <= 1'b0;
            out_err   <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            div_ena   <= 1'b0;
            div_rst   <= 1'b0;
            wait_cnt  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        neg_q    <= neg_a ^ neg_b;
                        neg_r    <= neg_a;
                        if (in_b == '0) begin
                            out_q     <= ONES;
                            out_r     <= in_a;
                            out_dz    <= 1'b1;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (in_signed && in_a == MIN && in_b == ONES) begin
                            // The only signed overflow; the divider never sees it.
                            out_q     <= MIN;
                            out_r     <= '0;
                            out_dz    <= 1'b0;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            div_a   <= mag_a;
                            div_b   <= mag_b;
                            div_rst <= 1'b1;
                            div_ena <= 1'b1;
                            state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    div_rst  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // dne in the first WAIT cycle may still belong to the previous op.
                    if (wait_cnt != '0 && div_dne) begin
                        div_ena <= 1'b0;
                        state   <= S_FIX;
                    end else if (wait_cnt == LAST) begin
                        div_ena   <= 1'b0;
                        out_q     <= '0;
                        out_r     <= '0;
                        out_dz    <= 1'b0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    out_q     <= neg_q ? -div_q : div_q;
                    out_r     <= neg_r ? -div_r : div_r;
                    out_dz    <= 1'b0;
                    out_err   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_32_seq.sv
// Directed bench for divider_32_seq with a behavioural divider_32 stand-in.
module tb_divider_32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_q, out_r;
    logic        out_dz, out_err;
    logic [31:0] div_a, div_b;
    logic        div_ena, div_rst;
    logic [31:0] div_q = '0;
    logic [31:0] div_r = '0;
    logic        div_dne = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit hang = 1'b0;
    int dcnt = 0;

    divider_32_seq #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_err(out_err),
        .div_a(div_a), .div_b(div_b), .div_ena(div_ena), .div_rst(div_rst),
        .div_q(div_q), .div_r(div_r), .div_dne(div_dne)
    );

    always #5 clk = ~clk;

    // Stand-in divider: restarts on rst&ena, answers 5 enabled cycles later, holds dne.
    always @(posedge clk) begin
        if (div_ena && div_rst) begin
            dcnt    <= 5;
            div_dne <= 1'b0;
        end else if (div_ena && !hang && dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                div_dne <= 1'b1;
                div_q   <= div_a / div_b;
                div_r   <= div_a % div_b;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request and returns the result plus latency and divider-start count.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic err, output int lat,
                         output int starts, output logic [31:0] ca, output logic [31:0] cb);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_signed = sg; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; starts = 0; ca = '0; cb = '0;
        do begin
            @(negedge clk);
            lat++;
            if (div_rst) begin
                starts++;
                ca = div_a;
                cb = div_b;
            end
        end while (!out_valid && lat < 200);
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        q = out_q; r = out_r; dz = out_dz; err = out_err;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        special;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] q, r, ca, cb, hq;
        logic        dz, err;
        int          lat, starts;

        vecs[0]  = '{32'd155,        32'd25,         1'b0, 32'd6,        32'd5,        1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFF65,   32'd25,         1'b1, 32'hFFFFFFFA, 32'hFFFFFFFB, 1'b0, 1'b0};
        vecs[2]  = '{32'd7,          32'd0,          1'b0, 32'hFFFFFFFF, 32'd7,        1'b1, 1'b1};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1};
        vecs[4]  = '{32'd155,        32'hFFFFFFE7,   1'b1, 32'hFFFFFFFA, 32'd5,        1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFF65,   32'hFFFFFFE7,   1'b1, 32'd6,        32'hFFFFFFFB, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};
        vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b1};
        vecs[9]  = '{32'h80000000,   32'd1,          1'b1, 32'h80000000, 32'd0,        1'b0, 1'b0};
        vecs[10] = '{32'd0,          32'd5,          1'b0, 32'd0,        32'd0,        1'b0, 1'b0};
        vecs[11] = '{32'd100,        32'd7,          1'b1, 32'd14,       32'd2,        1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_ena",   32'(div_ena),   32'd0);
        chk("rst_div_rst",   32'(div_rst),   32'd0);
        chk("rst_out_q",     out_q,          32'd0);
        chk("rst_out_r",     out_r,          32'd0);
        chk("rst_flags",     {30'd0, out_dz, out_err}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sg, q, r, dz, err, lat, starts, ca, cb);
            chk($sformatf("v%0d_q", i),   q,          vecs[i].q);
            chk($sformatf("v%0d_r", i),   r,          vecs[i].r);
            chk($sformatf("v%0d_dz", i),  32'(dz),    32'(vecs[i].dz));
            chk($sformatf("v%0d_err", i), 32'(err),   32'd0);
            chk($sformatf("v%0d_starts", i), 32'(starts), vecs[i].special ? 32'd0 : 32'd1);
            if (vecs[i].special) chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
            if (i == 1) begin
                chk("v1_div_a", ca, 32'd155);
                chk("v1_div_b", cb, 32'd25);
            end
            release_out();
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
        end

        // Consumer stalls for 10 cycles; result and handshake must hold.
        do_op(32'd155, 32'd25, 1'b0, q, r, dz, err, lat, starts, ca, cb);
        hq = out_q;
        in_a = 32'd9; in_b = 32'd3; in_signed = 1'b0; in_valid = 1'b1;
        begin
            int bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (!out_valid || in_ready || out_q !== hq || out_r !== 32'd5) bad++;
            end
            chk("stall_stable_cycles_bad", 32'(bad), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        do_op(32'd9, 32'd3, 1'b0, q, r, dz, err, lat, starts, ca, cb);
        chk("after_stall_q", q, 32'd3);
        release_out();

        // Reset while the divider is busy: op dropped, no output.
        hang = 1'b1;
        @(negedge clk);
        in_a = 32'd155; in_b = 32'd25; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midwait_div_ena", 32'(div_ena), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_rst_in_ready",  32'(in_ready),  32'd1);
        chk("midwait_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midwait_rst_div_ena",   32'(div_ena),   32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midwait_no_output", 32'(out_valid), 32'd0);

        // Divider never answers: timeout result.
        do_op(32'd155, 32'd25, 1'b0, q, r, dz, err, lat, starts, ca, cb);
        chk("to_err", 32'(err), 32'd1);
        chk("to_q",   q,        32'd0);
        chk("to_r",   r,        32'd0);
        chk("to_dz",  32'(dz),  32'd0);
        if (lat < 64) chk("to_lat_min", 32'(lat), 32'd64);
        release_out();
        hang = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, q, r, dz, err, lat, starts, ca, cb);
        chk("post_to_err_clear", 32'(err), 32'd0);
        chk("post_to_q",         q,        32'd14);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
